// File: rtl/presc_event_counter_pkg.sv
// Shared constants for the prescaled event counter: direction/mode encodings and default sizes.
package presc_event_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int DEFAULT_TICK_DIV = 2500;
  localparam int DEFAULT_PRESC_W  = 12;
  localparam int DEFAULT_CNT_W    = 8;

endpackage

// File: rtl/presc_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and strobes tick_o in the last cycle of each period.
module presc_tick_gen #(
  parameter int TICK_DIV = 2500,
  parameter int PRESC_W  = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick_o
);

  if (TICK_DIV < 2 || 64'(TICK_DIV) > (64'd1 << PRESC_W)) begin : g_bad_params
    $error("presc_tick_gen: TICK_DIV must be >= 2 and fit in PRESC_W bits");
  end

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      if (presc == PRESC_LAST) presc <= '0;
      else                     presc <= presc + 1'b1;
    end
  end

  // Gated by en so a paused prescaler parked on the last count never strobes.
  assign tick_o = en & (presc == PRESC_LAST);

endmodule

// File: rtl/presc_event_counter.sv
// Prescaled up/down event counter with wrap/saturate, clear, load and compare match.
// Optional capture port enabled by defining PRESC_EVENT_COUNTER_CAPTURE_EN.
module presc_event_counter
  import presc_event_counter_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int PRESC_W  = DEFAULT_PRESC_W,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  input  logic [CNT_W-1:0] cmp_val,
  output logic             tick_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             match_o,
  output logic             wrap_o
`ifdef PRESC_EVENT_COUNTER_CAPTURE_EN
  ,
  input  logic             cap_i,
  output logic [CNT_W-1:0] cap_o
`endif
);

  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("presc_event_counter: CNT_W must be >= 2");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             tick;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap_nxt;

  presc_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .PRESC_W  (PRESC_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clr    (clr),
    .tick_o (tick)
  );

  assign tick_o = tick;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_nxt  = cnt_o;
    wrap_nxt = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = load_val;
    end else if (tick) begin
      case (dir)
        DIR_UP: begin
          if (cnt_o == CNT_MAX) begin
            wrap_nxt = 1'b1;
            cnt_nxt  = (sat == MODE_SAT) ? cnt_o : '0;
          end else begin
            cnt_nxt = cnt_o + 1'b1;
          end
        end
        DIR_DOWN: begin
          if (cnt_o == '0) begin
            wrap_nxt = 1'b1;
            cnt_nxt  = (sat == MODE_WRAP) ? CNT_MAX : cnt_o;
          end else begin
            cnt_nxt = cnt_o - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_o  <= '0;
      wrap_o <= 1'b0;
    end else begin
      cnt_o  <= cnt_nxt;
      wrap_o <= wrap_nxt;
    end
  end

  assign match_o = (cnt_o == cmp_val);

`ifdef PRESC_EVENT_COUNTER_CAPTURE_EN
  // Captures the next-state value so a same-cycle step, load or clear is included; clr leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cap_o <= '0;
    else if (cap_i) cap_o <= cnt_nxt;
  end
`endif

endmodule
